// File: rtl/pzcorebus_pkg.sv
// pzcorebus_pkg
// Shared pzcorebus types and helpers used by the request protocol checker:
//   - pzcorebus_profile / pzcorebus_command_type enums
//   - pzcorebus_config: profile, field widths and max_length of one bus link
//   - is_memory_profile(), is_command_with_data()
//   - get_length_width(), get_unpacked_length()
package pzcorebus_pkg;

  typedef enum logic [1:0] {
    PZCOREBUS_CSR      = 2'b00,
    PZCOREBUS_MEMORY_H = 2'b01,
    PZCOREBUS_MEMORY_L = 2'b10
  } pzcorebus_profile;

  typedef enum logic [2:0] {
    PZCOREBUS_NULL_COMMAND     = 3'b000,
    PZCOREBUS_READ             = 3'b001,
    PZCOREBUS_WRITE            = 3'b010,
    PZCOREBUS_WRITE_NON_POSTED = 3'b011,
    PZCOREBUS_ATOMIC           = 3'b100
  } pzcorebus_command_type;

  typedef struct packed {
    pzcorebus_profile profile;
    int               id_width;
    int               address_width;
    int               data_width;
    int               unit_data_width;
    int               max_length;
    int               param_width;
    int               info_width;
  } pzcorebus_config;

  // A zero-width default would not elaborate, so the default is a small memory link.
  localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
    profile:         PZCOREBUS_MEMORY_H,
    id_width:        4,
    address_width:   32,
    data_width:      128,
    unit_data_width: 32,
    max_length:      64,
    param_width:     4,
    info_width:      4
  };

  function automatic logic is_memory_profile(pzcorebus_config cfg);
    return (cfg.profile != PZCOREBUS_CSR);
  endfunction

  function automatic logic is_command_with_data(pzcorebus_command_type cmd);
    return (cmd == PZCOREBUS_WRITE) || (cmd == PZCOREBUS_WRITE_NON_POSTED) ||
           (cmd == PZCOREBUS_ATOMIC);
  endfunction

  function automatic int get_length_width(pzcorebus_config cfg);
    return (cfg.max_length > 1) ? $clog2(cfg.max_length) : 1;
  endfunction

  // mlength==0 encodes the maximum burst length.
  function automatic int get_unpacked_length(pzcorebus_config cfg, int length);
    return (length == 0) ? cfg.max_length : length;
  endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// pzcorebus_if
// Request side (command + write data) of a pzcorebus link.
//   master  : drives the m* fields, samples the accepts
//   slave   : samples the m* fields, drives the accepts
//   monitor : read-only view for passive checkers
interface pzcorebus_if
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = PZCOREBUS_DEFAULT_CONFIG
);
  localparam int LEN_W = get_length_width(BUS_CONFIG);

  logic                                 mcmd_valid;
  logic                                 scmd_accept;
  pzcorebus_command_type                mcmd;
  logic [BUS_CONFIG.id_width-1:0]       mid;
  logic [BUS_CONFIG.address_width-1:0]  maddr;
  logic [LEN_W-1:0]                     mlength;
  logic [BUS_CONFIG.param_width-1:0]    mparam;
  logic [BUS_CONFIG.info_width-1:0]     minfo;
  logic                                 mdata_valid;
  logic                                 sdata_accept;
  logic [BUS_CONFIG.data_width-1:0]     mdata;
  logic [BUS_CONFIG.data_width/8-1:0]   mdata_byteen;
  logic                                 mdata_last;

  modport master (
    output mcmd_valid, mcmd, mid, maddr, mlength, mparam, minfo,
    output mdata_valid, mdata, mdata_byteen, mdata_last,
    input  scmd_accept, sdata_accept
  );

  modport slave (
    input  mcmd_valid, mcmd, mid, maddr, mlength, mparam, minfo,
    input  mdata_valid, mdata, mdata_byteen, mdata_last,
    output scmd_accept, sdata_accept
  );

  modport monitor (
    input mcmd_valid, scmd_accept, mcmd, mid, maddr, mlength, mparam, minfo,
    input mdata_valid, sdata_accept, mdata, mdata_byteen, mdata_last
  );

endinterface

// File: rtl/pzcorebus_request_beat_tracker.sv
// pzcorebus_request_beat_tracker
// Tracks expected write-data beat counts against observed data bursts.
//   i_cmd_push  : command with data accepted this cycle, i_cmd_beats beats expected
//   i_beat      : data beat accepted this cycle, i_last = its mdata_last
//   o_error     : combinational pulse; last-beat mismatch or queue overflow this cycle
// Data may lead its command: complete bursts seen before any command entry are
// queued as observed beat counts and matched against command entries in order.
module pzcorebus_request_beat_tracker #(
  parameter int BEAT_W = 5
)(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_push,
  input  logic [BEAT_W-1:0] i_cmd_beats,
  input  logic              i_beat,
  input  logic              i_last,
  output logic              o_error
);
  localparam int             DEPTH      = 4;
  localparam int             PTR_W      = 2;
  localparam logic [PTR_W:0] FULL_COUNT = 3'd4;

  logic [BEAT_W-1:0] cmd_fifo_r  [DEPTH];
  logic [BEAT_W-1:0] lead_fifo_r [DEPTH];
  logic [PTR_W-1:0]  cmd_wr_r, cmd_rd_r, lead_wr_r, lead_rd_r;
  logic [PTR_W:0]    cmd_cnt_r, lead_cnt_r;
  logic [BEAT_W-1:0] beat_cnt_r;

  logic              cmd_empty_s, cmd_full_s, lead_empty_s, lead_full_s;
  logic [BEAT_W-1:0] head_s;
  logic              head_valid_s, inline_s, exp_last_s, inline_end_s, match_s;
  logic              cmd_pop_s, cmd_write_s, cmd_store_s;
  logic              lead_write_s, lead_store_s, lead_pop_s;

  // Queue status, head selection (bypass of a same-cycle push) and error detection
  always_comb begin
    cmd_empty_s  = (cmd_cnt_r == '0);
    cmd_full_s   = (cmd_cnt_r == FULL_COUNT);
    lead_empty_s = (lead_cnt_r == '0);
    lead_full_s  = (lead_cnt_r == FULL_COUNT);
    head_s       = cmd_empty_s ? i_cmd_beats : cmd_fifo_r[cmd_rd_r];
    head_valid_s = !cmd_empty_s || i_cmd_push;
    // Inline checking only when no earlier data-first burst is still waiting.
    inline_s     = i_beat && head_valid_s && lead_empty_s;
    exp_last_s   = (beat_cnt_r == (head_s - BEAT_W'(1)));
    inline_end_s = inline_s && (i_last || exp_last_s);
    match_s      = !cmd_empty_s && !lead_empty_s;
    cmd_pop_s    = (inline_end_s && !cmd_empty_s) || match_s;
    cmd_write_s  = i_cmd_push && !(inline_end_s && cmd_empty_s);
    cmd_store_s  = cmd_write_s && (!cmd_full_s || cmd_pop_s);
    lead_write_s = i_beat && !inline_s && i_last;
    lead_pop_s   = match_s;
    lead_store_s = lead_write_s && (!lead_full_s || lead_pop_s);
    o_error      = (inline_s && (i_last != exp_last_s)) ||
                   (match_s && (lead_fifo_r[lead_rd_r] != cmd_fifo_r[cmd_rd_r])) ||
                   (cmd_write_s && !cmd_store_s) ||
                   (lead_write_s && !lead_store_s);
  end

  // Queue storage, pointers, occupancy and the running beat counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cmd_fifo_r[i]  <= '0;
        lead_fifo_r[i] <= '0;
      end
      cmd_wr_r   <= '0;
      cmd_rd_r   <= '0;
      lead_wr_r  <= '0;
      lead_rd_r  <= '0;
      cmd_cnt_r  <= '0;
      lead_cnt_r <= '0;
      beat_cnt_r <= '0;
    end else begin
      if (cmd_store_s) begin
        cmd_fifo_r[cmd_wr_r] <= i_cmd_beats;
        cmd_wr_r             <= cmd_wr_r + PTR_W'(1);
      end
      if (cmd_pop_s) begin
        cmd_rd_r <= cmd_rd_r + PTR_W'(1);
      end
      if (lead_store_s) begin
        lead_fifo_r[lead_wr_r] <= beat_cnt_r + BEAT_W'(1);
        lead_wr_r              <= lead_wr_r + PTR_W'(1);
      end
      if (lead_pop_s) begin
        lead_rd_r <= lead_rd_r + PTR_W'(1);
      end
      cmd_cnt_r  <= cmd_cnt_r + {{PTR_W{1'b0}}, cmd_store_s} - {{PTR_W{1'b0}}, cmd_pop_s};
      lead_cnt_r <= lead_cnt_r + {{PTR_W{1'b0}}, lead_store_s} - {{PTR_W{1'b0}}, lead_pop_s};
      if (i_beat) begin
        beat_cnt_r <= (inline_end_s || lead_write_s) ? '0 : beat_cnt_r + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pzcorebus_request_protocol_checker.sv
// pzcorebus_request_protocol_checker
// Passive monitor for the request side of a pzcorebus link; never drives the bus.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset (only way to clear flags)
//   bus_if           : monitor view of the link
//   o_cmd_unstable   : sticky, command changed or dropped while pending
//   o_data_unstable  : sticky, write data changed or dropped while pending
//   o_last_error     : sticky, mdata_last disagrees with the expected beat count
//   o_x_error        : sticky, X/Z on mcmd_valid or mdata_valid out of reset
// SVA_CHECKER=0 makes the block inert. SVA_MESSAGE=0 keeps the flags but silences
// the $error reports, for benches that provoke violations on purpose.
module pzcorebus_request_protocol_checker
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG  = PZCOREBUS_DEFAULT_CONFIG,
  parameter bit              SVA_CHECKER = 1'b1,
  parameter bit              SVA_MESSAGE = 1'b1
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  pzcorebus_if.monitor bus_if,
  output logic         o_cmd_unstable,
  output logic         o_data_unstable,
  output logic         o_last_error,
  output logic         o_x_error
);
  localparam int LEN_W  = get_length_width(BUS_CONFIG);
  localparam int RATIO  = BUS_CONFIG.data_width / BUS_CONFIG.unit_data_width;
  localparam int BEAT_W = $clog2(((BUS_CONFIG.max_length + RATIO - 1) / RATIO) + 1);
  localparam int CMD_W  = $bits(pzcorebus_command_type) + BUS_CONFIG.id_width +
                          BUS_CONFIG.address_width + LEN_W + BUS_CONFIG.param_width +
                          BUS_CONFIG.info_width;
  localparam int DAT_W  = BUS_CONFIG.data_width + BUS_CONFIG.data_width / 8 + 1;

  logic [CMD_W-1:0] cmd_fields_s, cmd_snap_r;
  logic [DAT_W-1:0] data_fields_s, data_snap_r;
  logic             cmd_pending_r, data_pending_r;
  logic             cmd_viol_s, data_viol_s, last_viol_s, x_viol_s;
  logic             cmd_unstable_r, data_unstable_r, last_error_r, x_error_r;

  assign cmd_fields_s  = {bus_if.mcmd, bus_if.mid, bus_if.maddr, bus_if.mlength,
                          bus_if.mparam, bus_if.minfo};
  assign data_fields_s = {bus_if.mdata, bus_if.mdata_byteen, bus_if.mdata_last};

  if (SVA_CHECKER && is_memory_profile(BUS_CONFIG)) begin : g_beat_tracker
    logic              cmd_data_ack_s;
    logic [BEAT_W-1:0] cmd_beats_s;
    logic              tracker_error_s;

    assign cmd_data_ack_s = bus_if.mcmd_valid && bus_if.scmd_accept &&
                            is_command_with_data(bus_if.mcmd);
    assign cmd_beats_s    = BEAT_W'((get_unpacked_length(BUS_CONFIG, int'(bus_if.mlength)) +
                                     RATIO - 1) / RATIO);

    pzcorebus_request_beat_tracker #(
      .BEAT_W (BEAT_W)
    ) u_beat_tracker (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cmd_push  (cmd_data_ack_s),
      .i_cmd_beats (cmd_beats_s),
      .i_beat      (bus_if.mdata_valid && bus_if.sdata_accept),
      .i_last      (bus_if.mdata_last),
      .o_error     (tracker_error_s)
    );
    assign last_viol_s = tracker_error_s;
  end else begin : g_no_beat_tracker
    assign last_viol_s = 1'b0;
  end

  // Violations seen at the coming edge, compared against the pending snapshots
  always_comb begin
    cmd_viol_s  = 1'b0;
    data_viol_s = 1'b0;
    x_viol_s    = 1'b0;
    if (SVA_CHECKER) begin
      cmd_viol_s  = cmd_pending_r && (!bus_if.mcmd_valid || (cmd_fields_s != cmd_snap_r));
      data_viol_s = data_pending_r && (!bus_if.mdata_valid || (data_fields_s != data_snap_r));
      x_viol_s    = $isunknown(bus_if.mcmd_valid | bus_if.mdata_valid);
    end else begin
      cmd_viol_s  = 1'b0;
      data_viol_s = 1'b0;
      x_viol_s    = 1'b0;
    end
  end

  // Pending flags and snapshot of each channel taken at a not-accepted edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_pending_r  <= 1'b0;
      data_pending_r <= 1'b0;
      cmd_snap_r     <= '0;
      data_snap_r    <= '0;
    end else begin
      cmd_pending_r  <= bus_if.mcmd_valid && !bus_if.scmd_accept;
      data_pending_r <= bus_if.mdata_valid && !bus_if.sdata_accept;
      cmd_snap_r     <= cmd_fields_s;
      data_snap_r    <= data_fields_s;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_unstable_r  <= 1'b0;
      data_unstable_r <= 1'b0;
      last_error_r    <= 1'b0;
      x_error_r       <= 1'b0;
    end else begin
      cmd_unstable_r  <= cmd_unstable_r | cmd_viol_s;
      data_unstable_r <= data_unstable_r | data_viol_s;
      last_error_r    <= last_error_r | last_viol_s;
      x_error_r       <= x_error_r | x_viol_s;
    end
  end

  assign o_cmd_unstable  = cmd_unstable_r;
  assign o_data_unstable = data_unstable_r;
  assign o_last_error    = last_error_r;
  assign o_x_error       = x_error_r;

  if (SVA_CHECKER && SVA_MESSAGE) begin : g_sva
    ap_cmd_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (bus_if.mcmd_valid && !bus_if.scmd_accept) |=>
        (bus_if.mcmd_valid && $stable(cmd_fields_s)))
      else $error("pzcorebus: command changed while pending");
    ap_data_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (bus_if.mdata_valid && !bus_if.sdata_accept) |=>
        (bus_if.mdata_valid && $stable(data_fields_s)))
      else $error("pzcorebus: write data changed while pending");
    ap_burst_last: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !last_viol_s)
      else $error("pzcorebus: mdata_last does not match expected beat count");
    ap_no_x: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !$isunknown(bus_if.mcmd_valid | bus_if.mdata_valid))
      else $error("pzcorebus: X/Z on mcmd_valid or mdata_valid");
  end

endmodule

// File: tb/tb_pzcorebus_request_protocol_checker.sv
// Bench for pzcorebus_request_protocol_checker: a table of per-cycle stimulus with
// expected flags after each edge, plus hand-written 16-beat and X sequences.
// A second, inert instance (SVA_CHECKER=0) watches the same bus; its flags must stay 0.
module tb_pzcorebus_request_protocol_checker;
  import pzcorebus_pkg::*;

  localparam pzcorebus_config CFG = '{
    profile: PZCOREBUS_MEMORY_H, id_width: 4, address_width: 32, data_width: 128,
    unit_data_width: 32, max_length: 64, param_width: 4, info_width: 4
  };

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  pzcorebus_if #(.BUS_CONFIG(CFG)) bus_if ();

  logic o_cmd_unstable, o_data_unstable, o_last_error, o_x_error;
  logic z_cmd_unstable, z_data_unstable, z_last_error, z_x_error;

  pzcorebus_request_protocol_checker #(
    .BUS_CONFIG (CFG), .SVA_CHECKER (1'b1), .SVA_MESSAGE (1'b0)
  ) dut (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .bus_if (bus_if),
    .o_cmd_unstable (o_cmd_unstable), .o_data_unstable (o_data_unstable),
    .o_last_error (o_last_error), .o_x_error (o_x_error)
  );

  pzcorebus_request_protocol_checker #(
    .BUS_CONFIG (CFG), .SVA_CHECKER (1'b0), .SVA_MESSAGE (1'b0)
  ) u_inert (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .bus_if (bus_if),
    .o_cmd_unstable (z_cmd_unstable), .o_data_unstable (z_data_unstable),
    .o_last_error (z_last_error), .o_x_error (z_x_error)
  );

  typedef struct {
    string                 tag;
    logic                  rst_n;
    logic                  cv;
    logic                  ca;
    pzcorebus_command_type cmd;
    logic [31:0]           addr;
    logic [5:0]            len;
    logic                  dv;
    logic                  da;
    logic                  dl;
    logic [127:0]          data;
    logic [2:0]            exp;   // {cmd_unstable, data_unstable, last_error}
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic x_bit;
  logic exp_x;

  task automatic add(input string tag, input logic rst_n, input logic cv, input logic ca,
                     input pzcorebus_command_type cmd, input logic [31:0] addr,
                     input logic [5:0] len, input logic dv, input logic da, input logic dl,
                     input logic [127:0] data, input logic [2:0] exp);
    vec_t r;
    r.tag = tag; r.rst_n = rst_n; r.cv = cv; r.ca = ca; r.cmd = cmd; r.addr = addr;
    r.len = len; r.dv = dv; r.da = da; r.dl = dl; r.data = data; r.exp = exp;
    vecs.push_back(r);
  endtask

  task automatic idle(input string tag, input logic rst_n, input logic [2:0] exp);
    add(tag, rst_n, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0,
        1'b0, 1'b0, 1'b0, 128'h0, exp);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t r);
    @(negedge i_clk);
    i_rst_n                = r.rst_n;
    bus_if.mcmd_valid      = r.cv;
    bus_if.scmd_accept     = r.ca;
    bus_if.mcmd            = r.cmd;
    bus_if.maddr           = r.addr;
    bus_if.mlength         = r.len;
    bus_if.mdata_valid     = r.dv;
    bus_if.sdata_accept    = r.da;
    bus_if.mdata_last      = r.dl;
    bus_if.mdata           = r.data;
    @(posedge i_clk);
    #1;
    check({r.tag, " flags"}, {1'b0, o_cmd_unstable, o_data_unstable, o_last_error},
          {1'b0, r.exp});
    check({r.tag, " x"}, {3'b000, o_x_error}, 4'b0000);
    check({r.tag, " inert"}, {z_cmd_unstable, z_data_unstable, z_last_error, z_x_error},
          4'b0000);
  endtask

  initial begin
    bus_if.mid          = '0;
    bus_if.mparam       = '0;
    bus_if.minfo        = '0;
    bus_if.mdata_byteen = '1;

    // Clean 2-beat write (mlength 8) with a stalled, stable second beat
    idle("a_rst", 1'b0, 3'b000);
    idle("a_rel", 1'b1, 3'b000);
    add("a_cmd_b1", 1'b1, 1'b1, 1'b1, PZCOREBUS_WRITE, 32'h100, 6'd8, 1'b1, 1'b1, 1'b0, 128'h11, 3'b000);
    add("a_b2_wait", 1'b1, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0, 1'b1, 1'b0, 1'b1, 128'h22, 3'b000);
    add("a_b2_acc", 1'b1, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0, 1'b1, 1'b1, 1'b1, 128'h22, 3'b000);
    idle("a_idle", 1'b1, 3'b000);
    // Pending command whose address moves 0x100 -> 0x140
    idle("b_rst", 1'b0, 3'b000);
    idle("b_rel", 1'b1, 3'b000);
    add("b_pend", 1'b1, 1'b1, 1'b0, PZCOREBUS_READ, 32'h100, 6'd4, 1'b0, 1'b0, 1'b0, 128'h0, 3'b000);
    add("b_move", 1'b1, 1'b1, 1'b0, PZCOREBUS_READ, 32'h140, 6'd4, 1'b0, 1'b0, 1'b0, 128'h0, 3'b100);
    add("b_acc", 1'b1, 1'b1, 1'b1, PZCOREBUS_READ, 32'h140, 6'd4, 1'b0, 1'b0, 1'b0, 128'h0, 3'b100);
    idle("b_idle", 1'b1, 3'b100);
    // Pending data whose valid drops before accept
    idle("c_rst", 1'b0, 3'b000);
    idle("c_rel", 1'b1, 3'b000);
    add("c_pend", 1'b1, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 128'hAA, 3'b000);
    idle("c_drop", 1'b1, 3'b010);
    idle("c_idle", 1'b1, 3'b010);
    // Data leads its command by two beats, then a lone last beat that disagrees
    idle("e_rst", 1'b0, 3'b000);
    idle("e_rel", 1'b1, 3'b000);
    add("e_b1", 1'b1, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0, 1'b1, 1'b1, 1'b0, 128'h1, 3'b000);
    add("e_b2", 1'b1, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0, 1'b1, 1'b1, 1'b1, 128'h2, 3'b000);
    add("e_cmd", 1'b1, 1'b1, 1'b1, PZCOREBUS_WRITE, 32'h200, 6'd8, 1'b0, 1'b0, 1'b0, 128'h0, 3'b000);
    idle("e_match", 1'b1, 3'b000);
    idle("e_idle", 1'b1, 3'b000);
    add("e_short", 1'b1, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0, 1'b1, 1'b1, 1'b1, 128'h3, 3'b000);
    add("e_cmd2", 1'b1, 1'b1, 1'b1, PZCOREBUS_WRITE, 32'h300, 6'd8, 1'b0, 1'b0, 1'b0, 128'h0, 3'b000);
    idle("e_mismatch", 1'b1, 3'b001);
    // Reset mid-burst clears a set flag and drops the half-done burst
    idle("f_rst", 1'b0, 3'b000);
    idle("f_rel", 1'b1, 3'b000);
    add("f_pend", 1'b1, 1'b0, 1'b0, PZCOREBUS_NULL_COMMAND, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 128'h5, 3'b000);
    idle("f_drop", 1'b1, 3'b010);
    add("f_half", 1'b1, 1'b1, 1'b1, PZCOREBUS_WRITE, 32'h400, 6'd8, 1'b1, 1'b1, 1'b0, 128'h6, 3'b010);
    idle("f_pulse", 1'b0, 3'b000);
    idle("f_rel2", 1'b1, 3'b000);
    add("f_one", 1'b1, 1'b1, 1'b1, PZCOREBUS_WRITE, 32'h500, 6'd4, 1'b1, 1'b1, 1'b1, 128'h7, 3'b000);
    idle("f_idle", 1'b1, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // mlength 0 means 64 units = 16 beats; last raised early on beat 15
    begin
      vec_t r;
      idle("d_rst", 1'b0, 3'b000);
      idle("d_rel", 1'b1, 3'b000);
      apply(vecs[vecs.size() - 2]);
      apply(vecs[vecs.size() - 1]);
      r = vecs[0];
      r.tag = "d_cmd_b1"; r.rst_n = 1'b1; r.cv = 1'b1; r.ca = 1'b1; r.cmd = PZCOREBUS_WRITE;
      r.addr = 32'h600; r.len = 6'd0; r.dv = 1'b1; r.da = 1'b1; r.dl = 1'b0; r.exp = 3'b000;
      apply(r);
      for (int b = 2; b <= 14; b++) begin
        r.tag = $sformatf("d_b%0d", b); r.cv = 1'b0; r.ca = 1'b0;
        r.cmd = PZCOREBUS_NULL_COMMAND; r.data = 128'(b);
        apply(r);
      end
      r.tag = "d_b15_last"; r.dl = 1'b1; r.exp = 3'b001;
      apply(r);
      r.tag = "d_idle"; r.dv = 1'b0; r.da = 1'b0; r.dl = 1'b0;
      apply(r);
    end

    // X on mcmd_valid one cycle after reset release
    begin
      vec_t r;
      r = vecs[0];
      apply(r);
      r.rst_n = 1'b1; r.tag = "x_rel";
      apply(r);
      @(negedge i_clk);
      x_bit              = 1'bx;
      exp_x              = $isunknown(x_bit | 1'b0);
      bus_if.mcmd_valid  = x_bit;
      bus_if.scmd_accept = 1'b1;
      bus_if.mcmd        = PZCOREBUS_READ;
      bus_if.mdata_valid = 1'b0;
      @(posedge i_clk);
      #1;
      check("x_seen", {o_cmd_unstable, o_data_unstable, o_last_error, o_x_error},
            {3'b000, exp_x});
      check("x_inert", {z_cmd_unstable, z_data_unstable, z_last_error, z_x_error}, 4'b0000);
      @(negedge i_clk);
      bus_if.mcmd_valid = 1'b0;
      @(posedge i_clk);
      #1;
      check("x_sticky", {3'b000, o_x_error}, {3'b000, exp_x});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
